// File: rtl/pll_mdrp_sequencer.sv
// Programming sequencer for a Gowin PLL MDRP port.
// It holds the PLL in reset and writes one register profile from INIT_TABLE, reading each byte
// back when VERIFY is set. It then releases reset and qualifies lock over 16 consecutive cycles,
// with a timeout and a bounded number of full retries. Profiles can be switched at runtime, and
// bypass hands the MDRP port to the user.
// Ports:
//   mdclk, rst_n               clock, async active-low reset
//   bypass                     user MDRP passthrough, sequencer parked in RST_HOLD
//   reconf_req, reconf_sel     reprogram request (LOCKED/FAIL only) and profile index
//   busy, lock                 sequence in progress, qualified lock
//   err_verify, err_timeout    sticky read-back mismatch, retries exhausted
//   retry_cnt                  retries used in the current sequence
//   usr_md*                    user MDRP side (usr_mdrdo mirrors pll_mdrdo)
//   pll_rst, pll_lock, pll_md* PLL primitive side
module pll_mdrp_sequencer #(
    parameter int unsigned NUM_REGS     = 8,
    parameter int unsigned NUM_PROFILES = 2,
    parameter logic [NUM_PROFILES*NUM_REGS*8-1:0] INIT_TABLE = '0,
    parameter int unsigned BOOT_PROFILE = 0,
    parameter int unsigned VERIFY       = 1,
    parameter int unsigned RST_HOLD_CYC = 200,
    parameter int unsigned LOCK_TMO_CYC = 100000,
    parameter int unsigned MAX_RETRIES  = 3,
    localparam int unsigned PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
    localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          mdclk,
    input  logic          rst_n,
    input  logic          bypass,
    input  logic          reconf_req,
    input  logic [PW-1:0] reconf_sel,
    output logic          busy,
    output logic          lock,
    output logic          err_verify,
    output logic          err_timeout,
    output logic [RW-1:0] retry_cnt,
    input  logic [1:0]    usr_mdopc,
    input  logic          usr_mdainc,
    input  logic [7:0]    usr_mdwdi,
    output logic [7:0]    usr_mdrdo,
    output logic          pll_rst,
    input  logic          pll_lock,
    output logic [1:0]    pll_mdopc,
    output logic          pll_mdainc,
    output logic [7:0]    pll_mdwdi,
    input  logic [7:0]    pll_mdrdo
);

    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned HW = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC + 1) : 1;
    localparam int unsigned TW = (LOCK_TMO_CYC > 1) ? $clog2(LOCK_TMO_CYC + 1) : 1;

    localparam logic [HW-1:0] HOLD_LAST     = HW'(RST_HOLD_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST      = TW'(LOCK_TMO_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST      = IW'(NUM_REGS - 1);
    localparam logic [RW-1:0] RETRY_MAX     = RW'(MAX_RETRIES);
    localparam logic [3:0]    LOCK_RUN_LAST = 4'd15;

    typedef enum logic [3:0] {
        StRstHold, StWrite, StRead, StCheck, StInc,
        StRelease, StWaitLock, StRetry, StLocked, StFail
    } state_e;

    state_e        state_q;
    logic [HW-1:0] hold_cnt_q;
    logic [TW-1:0] tmr_q;
    logic [3:0]    lock_run_q;
    logic [IW-1:0] idx_q;
    logic [PW-1:0] prof_q;
    logic [RW-1:0] retry_q;
    logic          err_verify_q, err_timeout_q;
    logic          rst_q, busy_q, lock_q, ainc_q;
    logic [1:0]    opc_q;
    logic [7:0]    wdi_q;

    logic [7:0]    table_mem [NUM_PROFILES][NUM_REGS];
    logic [7:0]    cur_byte, next_byte;
    logic [PW-1:0] sel_prof;
    logic          byp;

    for (genvar p = 0; p < NUM_PROFILES; p++) begin : g_prof
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
            assign table_mem[p][r] = INIT_TABLE[(p*NUM_REGS+r)*8 +: 8];
        end
    end

    assign cur_byte  = table_mem[prof_q][idx_q];
    assign next_byte = table_mem[prof_q][idx_q + 1'b1];
    // Out-of-range profile requests fall back to profile 0.
    assign sel_prof  = (32'(reconf_sel) >= NUM_PROFILES) ? '0 : reconf_sel;

    always_ff @(posedge mdclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRstHold;
            hold_cnt_q    <= '0;
            tmr_q         <= '0;
            lock_run_q    <= '0;
            idx_q         <= '0;
            prof_q        <= PW'(BOOT_PROFILE);
            retry_q       <= '0;
            err_verify_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            rst_q         <= 1'b1;
            busy_q        <= 1'b1;
            lock_q        <= 1'b0;
            opc_q         <= 2'b00;
            ainc_q        <= 1'b0;
            wdi_q         <= '0;
        end else if (bypass) begin
            // Parked: a full sequence restarts from the latched profile once bypass drops.
            state_q    <= StRstHold;
            hold_cnt_q <= '0;
            idx_q      <= '0;
            rst_q      <= 1'b1;
            busy_q     <= 1'b1;
            lock_q     <= 1'b0;
            opc_q      <= 2'b00;
            ainc_q     <= 1'b0;
            wdi_q      <= '0;
        end else begin
            // MDRP strobes are single-cycle; states below re-assert them as needed.
            opc_q  <= 2'b00;
            ainc_q <= 1'b0;
            wdi_q  <= '0;
            unique case (state_q)
                StRstHold: begin
                    if (hold_cnt_q >= HOLD_LAST) begin
                        state_q <= StWrite;
                        opc_q   <= 2'b01;
                        wdi_q   <= cur_byte;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                StWrite: begin
                    if (VERIFY != 0) begin
                        state_q <= StRead;
                        opc_q   <= 2'b10;
                    end else begin
                        state_q <= StInc;
                        ainc_q  <= 1'b1;
                    end
                end
                StRead: state_q <= StCheck;
                StCheck: begin
                    if (pll_mdrdo != cur_byte) begin
                        err_verify_q <= 1'b1;
                        state_q      <= StRetry;
                    end else begin
                        state_q <= StInc;
                        ainc_q  <= 1'b1;
                    end
                end
                StInc: begin
                    if (idx_q == IDX_LAST) begin
                        state_q <= StRelease;
                        rst_q   <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StWrite;
                        opc_q   <= 2'b01;
                        wdi_q   <= next_byte;
                    end
                end
                StRelease: begin
                    tmr_q      <= '0;
                    lock_run_q <= '0;
                    state_q    <= StWaitLock;
                end
                StWaitLock: begin
                    if (pll_lock && lock_run_q == LOCK_RUN_LAST) begin
                        state_q <= StLocked;
                        lock_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (tmr_q >= TMO_LAST) begin
                        state_q <= StRetry;
                    end
                    if (!pll_lock) begin
                        lock_run_q <= '0;
                    end else if (lock_run_q != LOCK_RUN_LAST) begin
                        lock_run_q <= lock_run_q + 1'b1;
                    end
                    if (tmr_q < TMO_LAST) begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StRetry: begin
                    rst_q <= 1'b1;
                    if (retry_q == RETRY_MAX) begin
                        state_q       <= StFail;
                        err_timeout_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else begin
                        retry_q    <= retry_q + 1'b1;
                        idx_q      <= '0;
                        hold_cnt_q <= '0;
                        state_q    <= StRstHold;
                    end
                end
                StLocked, StFail: begin
                    // Lock loss in LOCKED re-sequences the same profile, retry count kept.
                    if (reconf_req || (state_q == StLocked && !pll_lock)) begin
                        state_q    <= StRstHold;
                        hold_cnt_q <= '0;
                        idx_q      <= '0;
                        rst_q      <= 1'b1;
                        busy_q     <= 1'b1;
                        lock_q     <= 1'b0;
                    end
                    if (reconf_req) begin
                        prof_q        <= sel_prof;
                        retry_q       <= '0;
                        err_timeout_q <= 1'b0;
                    end
                end
                default: state_q <= StRstHold;
            endcase
        end
    end

    // Reset overrides bypass so every output shows its reset value while rst_n is low.
    assign byp = bypass & rst_n;

    assign pll_rst     = byp ? 1'b0       : rst_q;
    assign busy        = byp ? 1'b0       : busy_q;
    // Raw lock gates the registered lock so a drop is seen in the same cycle.
    assign lock        = byp ? pll_lock   : (lock_q & pll_lock);
    assign pll_mdopc   = byp ? usr_mdopc  : opc_q;
    assign pll_mdainc  = byp ? usr_mdainc : ainc_q;
    assign pll_mdwdi   = byp ? usr_mdwdi  : wdi_q;
    assign usr_mdrdo   = pll_mdrdo;
    assign err_verify  = err_verify_q;
    assign err_timeout = err_timeout_q;
    assign retry_cnt   = retry_q;

endmodule
